proc_control: RTL and testbench

PROC_CONTROL -- requirements
Module: proc_control

---
 rtl/proc_pkg.sv | 38 +++
 rtl/proc_dec3to8.sv | 13 +
 rtl/proc_control.sv | 107 ++++++++++
 tb/tb_proc_control.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants and types for the processor control FSM.
// Opcodes, state encodings, word/register widths and the control-bundle struct.
package proc_pkg;

  localparam int WORD_W   = 9;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = 3;

  localparam logic [IDX_W-1:0] OP_MV  = 3'b000;
  localparam logic [IDX_W-1:0] OP_MVI = 3'b001;
  localparam logic [IDX_W-1:0] OP_ADD = 3'b010;
  localparam logic [IDX_W-1:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  // Field order mirrors the bus-mux select inputs so the bundle connects straight through.
  typedef struct packed {
    logic                irin;
    logic [NUM_REGS-1:0] rout;
    logic [NUM_REGS-1:0] rin;
    logic                gout;
    logic                dinout;
    logic                ain;
    logic                gin;
    logic                addsub;
    logic                done;
  } ctrl_t;

  function automatic logic is_alu(input logic [IDX_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/proc_dec3to8.sv
// 3-bit register index to 8-bit one-hot select; index 0 maps to the MSB.
module proc_dec3to8
  import proc_pkg::*;
(
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign onehot[NUM_REGS-1-i] = (idx == IDX_W'(i));
  end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control unit: IDLE fetches DIN into IR, T1..T3 sequence the bus,
// register enables and ALU for mv / mvi / add / sub.
module proc_control
  import proc_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Run,
  input  logic [WORD_W-1:0]   DIN,
  output logic                IRin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Gout,
  output logic                DINout,
  output logic                Ain,
  output logic                Gin,
  output logic                AddSub,
  output logic                Done
);

  state_t              state, nxt;
  logic [WORD_W-1:0]   ir;
  logic [IDX_W-1:0]    op;
  logic [NUM_REGS-1:0] sel_x, sel_y;
  ctrl_t               c;

  assign op = ir[8:6];

  proc_dec3to8 u_dec_x (.idx(ir[5:3]), .onehot(sel_x));
  proc_dec3to8 u_dec_y (.idx(ir[2:0]), .onehot(sel_y));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // IR only loads on an accepted Run, so it holds steady through T1..T3.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                        ir <= '0;
    else if (state == S_IDLE && Run)  ir <= DIN;
  end

  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = Run ? S_T1 : S_IDLE;
      S_T1:    nxt = is_alu(op) ? S_T2 : S_IDLE;
      S_T2:    nxt = is_alu(op) ? S_T3 : S_IDLE;
      S_T3:    nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    c = '0;
    if (!Reset) begin
      case (state)
        S_IDLE: c.irin = Run;
        S_T1: begin
          case (op)
            OP_MV: begin
              c.rout = sel_y;
              c.rin  = sel_x;
              c.done = 1'b1;
            end
            OP_MVI: begin
              c.dinout = 1'b1;
              c.rin    = sel_x;
              c.done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              c.rout = sel_x;
              c.ain  = 1'b1;
            end
            default: c.done = 1'b1;
          endcase
        end
        S_T2: begin
          if (is_alu(op)) begin
            c.rout   = sel_y;
            c.gin    = 1'b1;
            c.addsub = (op == OP_SUB);
          end
        end
        S_T3: begin
          if (is_alu(op)) begin
            c.gout = 1'b1;
            c.rin  = sel_x;
            c.done = 1'b1;
          end
        end
        default: c = '0;
      endcase
    end
  end

  assign IRin   = c.irin;
  assign Rout   = c.rout;
  assign Rin    = c.rin;
  assign Gout   = c.gout;
  assign DINout = c.dinout;
  assign Ain    = c.ain;
  assign Gin    = c.gin;
  assign AddSub = c.addsub;
  assign Done   = c.done;

endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a per-instruction schedule model.
module tb_proc_control;

  logic       Clock, Reset, Run;
  logic [8:0] DIN;
  logic       IRin, Gout, DINout, Ain, Gin, AddSub, Done;
  logic [7:0] Rout, Rin;

  typedef struct packed {
    logic       irin;
    logic [7:0] rout;
    logic [7:0] rin;
    logic       gout, dinout, ain, gin, addsub, done;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t got;
  vec_t sched[$];

  proc_control dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
    .IRin(IRin), .Rout(Rout), .Rin(Rin), .Gout(Gout), .DINout(DINout),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done)
  );

  assign got = {IRin, Rout, Rin, Gout, DINout, Ain, Gin, AddSub, Done};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [7:0] sel(input logic [2:0] n);
    logic [7:0] v;
    v = '0;
    v[7 - int'(n)] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input logic irin, input logic [7:0] rout, input logic [7:0] rin,
                              input logic gout, input logic dinout, input logic ain,
                              input logic gin, input logic addsub, input logic done);
    return {irin, rout, rin, gout, dinout, ain, gin, addsub, done};
  endfunction

  // Expected per-cycle outputs of one instruction, from fetch+1 until Done.
  task automatic push_instr(input logic [8:0] d);
    logic [2:0] op, x, y;
    op = d[8:6]; x = d[5:3]; y = d[2:0];
    case (op)
      3'b000: sched.push_back(mk(0, sel(y), sel(x), 0, 0, 0, 0, 0, 1));
      3'b001: sched.push_back(mk(0, 8'h00, sel(x), 0, 1, 0, 0, 0, 1));
      3'b010, 3'b011: begin
        sched.push_back(mk(0, sel(x), 8'h00, 0, 0, 1, 0, 0, 0));
        sched.push_back(mk(0, sel(y), 8'h00, 0, 0, 0, 1, op[0], 0));
        sched.push_back(mk(0, 8'h00, sel(x), 1, 0, 0, 0, 0, 1));
      end
      default: sched.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic chk(input string nm, input vec_t g, input vec_t w);
    n_cmp++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, g, w, $time);
    end
  endtask

  // Model compare: every negedge, then advance the model across the coming posedge.
  initial begin
    vec_t exp_v;
    int   drv;
    forever begin
      @(negedge Clock);
      if (Reset)                 exp_v = '0;
      else if (sched.size() > 0) exp_v = sched[0];
      else                       exp_v = mk(Run, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      chk("model", got, exp_v);
      drv = $countones(Rout) + int'(Gout) + int'(DINout);
      n_cmp++;
      if (drv > 1) begin
        n_bad++;
        $display("FAIL bus_excl: got %0d drivers want <=1 (t=%0t)", drv, $time);
      end
      if (Reset)                 sched.delete();
      else if (sched.size() > 0) void'(sched.pop_front());
      else if (Run)              push_instr(DIN);
    end
  end

  task automatic drive(input logic run, input logic [8:0] din);
    @(posedge Clock);
    #1;
    Run = run;
    DIN = din;
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = 9'b001_010_000;
    #2 chk("reset_outputs", got, '0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    chk("mvi_irin", got, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    drive(0, 9'h0AB);
    chk("mvi_t1", got, mk(0, 8'h00, 8'b0010_0000, 0, 1, 0, 0, 0, 1));
    drive(0, 9'h1FF);
    chk("mvi_idle", got, '0);

    drive(1, 9'b000_001_011);
    chk("mv_irin", got, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    drive(0, 9'($urandom));
    chk("mv_t1", got, mk(0, 8'b0001_0000, 8'b0100_0000, 0, 0, 0, 0, 0, 1));
    drive(0, 9'($urandom));

    drive(1, 9'b011_000_111);
    drive(0, 9'($urandom));
    chk("sub_t1", got, mk(0, 8'b1000_0000, 8'h00, 0, 0, 1, 0, 0, 0));
    drive(0, 9'($urandom));
    chk("sub_t2", got, mk(0, 8'b0000_0001, 8'h00, 0, 0, 0, 1, 1, 0));
    drive(0, 9'($urandom));
    chk("sub_t3", got, mk(0, 8'h00, 8'b1000_0000, 1, 0, 0, 0, 0, 1));
    drive(0, 9'($urandom));

    // Back-to-back adds with Run held high and DIN scrambled mid-instruction.
    drive(1, 9'b010_010_011);
    drive(1, 9'b000_111_111);
    chk("b2b_t1_hold", got, mk(0, 8'b0010_0000, 8'h00, 0, 0, 1, 0, 0, 0));
    drive(1, 9'b001_110_101);
    chk("b2b_t2_hold", got, mk(0, 8'b0001_0000, 8'h00, 0, 0, 0, 1, 0, 0));
    drive(1, 9'b111_000_000);
    chk("b2b_t3", got, mk(0, 8'h00, 8'b0010_0000, 1, 0, 0, 0, 0, 1));
    drive(1, 9'b010_101_110);
    chk("b2b_second_irin", got, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    drive(0, 9'($urandom));
    chk("b2b_second_t1", got, mk(0, 8'b0000_0100, 8'h00, 0, 0, 1, 0, 0, 0));
    drive(0, 9'($urandom));
    drive(0, 9'($urandom));
    drive(0, 9'($urandom));

    // Reset mid-instruction (during T2).
    drive(1, 9'b010_100_001);
    drive(0, 9'($urandom));
    @(posedge Clock);
    #3 Reset = 1'b1;
    #1 chk("reset_async_t2", got, '0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    Run = 1'b0;
    @(negedge Clock);
    chk("post_reset_idle", got, '0);
    drive(0, 9'($urandom));
    chk("post_reset_idle2", got, '0);

    drive(1, {3'b110, 6'($urandom)});
    drive(0, 9'($urandom));
    chk("illegal_t1", got, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
    drive(0, 9'($urandom));
    chk("illegal_idle", got, '0);

    for (int i = 0; i < 600; i++) begin
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      Run   = ($urandom_range(0, 9) < 6);
      DIN   = 9'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #2 Reset = 1'b1;
      end
      @(negedge Clock);
    end
    @(posedge Clock);
    #1 Reset = 1'b0;
    Run = 1'b0;
    repeat (6) @(negedge Clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
